// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
// Start/done handshake; a zero divisor finishes at once with an all-ones quotient.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q, d_q, r_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic [WIDTH:0]   r_shift;
  logic             sub_ok;
  logic [WIDTH-1:0] r_d, q_d;

  // The partial remainder stays below the divisor, so only its low WIDTH bits are stored.
  always_comb begin
    r_shift = {r_q, q_q[WIDTH-1]};
    sub_ok  = (r_shift >= {1'b0, d_q});
    r_d     = sub_ok ? WIDTH'(r_shift - {1'b0, d_q}) : r_shift[WIDTH-1:0];
    q_d     = {q_q[WIDTH-2:0], sub_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state_q <= DONE;
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= CALC;
              q_q     <= dividend;
              d_q     <= divisor;
              r_q     <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and random checks of seq_divider with WIDTH=8
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int compared = 0;
  int mismatched = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_done"}, {31'b0, done}, 0);
    check({tag, "_quot"}, {24'b0, quotient}, 0);
    check({tag, "_rem"}, {24'b0, remainder}, 0);
    check({tag, "_dbz"}, {31'b0, div_by_zero}, 0);
  endtask

  // Issues one division from IDLE (caller sits #1 after an edge) and checks it to completion.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input string tag);
    int lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    lat = 0;
    if (b != 0) check({tag, "_busy_at_E"}, {31'b0, busy}, 1);
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done !== 1'b1) check({tag, "_busy_mid"}, {31'b0, busy}, 1);
    end
    check({tag, "_lat"}, lat, (b == 0) ? 0 : W);
    check({tag, "_quot"}, {24'b0, quotient}, {24'b0, eq});
    check({tag, "_rem"}, {24'b0, remainder}, {24'b0, er});
    check({tag, "_dbz"}, {31'b0, div_by_zero}, (b == 0) ? 1 : 0);
    check({tag, "_busy_done"}, {31'b0, busy}, 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'b0, done}, 0);
  endtask

  initial begin
    int lat, pulses;
    logic [W-1:0] ra, rb, eq, er;

    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_div(8'd200, 8'd7, 8'd28, 8'd4, "d200_7");
    run_div(8'd255, 8'd1, 8'd255, 8'd0, "d255_1");
    run_div(8'd255, 8'd255, 8'd1, 8'd0, "d255_255");
    run_div(8'd5, 8'd9, 8'd0, 8'd5, "d5_9");
    run_div(8'd100, 8'd0, 8'd255, 8'd100, "d100_0");
    run_div(8'd100, 8'd10, 8'd10, 8'd0, "d100_10");

    // Second start during CALC must be ignored.
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    lat = 3; pulses = 0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    start = 1'b0;
    check("ign_lat", lat, W);
    check("ign_quot", {24'b0, quotient}, 28);
    check("ign_rem", {24'b0, remainder}, 4);
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    check("ign_extra_done", pulses, 0);
    check("ign_busy_idle", {31'b0, busy}, 0);

    // Asynchronous reset in the middle of a calculation.
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_busy", {31'b0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", {31'b0, done}, 0);
    run_div(8'd90, 8'd9, 8'd10, 8'd0, "d90_9");

    // Random regression against the bench's own arithmetic.
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
      if (rb == 0) begin
        eq = 8'hFF; er = ra;
      end else begin
        eq = ra / rb; er = ra % rb;
      end
      run_div(ra, rb, eq, er, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
